// File: rtl/core_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : core_decode_pipe
// Desc     : RV32I instruction decoder feeding a DEPTH-entry circular buffer
//            of decoded entries (op, register fields, immediate, pc, illegal
//            flag) with valid/ready handshakes on both sides and a flush.
//            Define DECODE_RV32M_EN to also decode the RV32M multiply/divide
//            group; without it those encodings are reported illegal.
// Revision : 1.0 - initial release
// ============================================================================
module core_decode_pipe #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal,
    output logic [3:0]      occupancy
);

    localparam int         PTR_W        = $clog2(DEPTH);
    localparam logic [3:0] C_DEPTH      = 4'(DEPTH);
    localparam logic [5:0] C_OP_ILLEGAL = 6'd63;

    typedef struct packed {
        logic [5:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Field extraction and immediate formats
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign w_f7     = in_inst[31:25];
    assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u  = {in_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                       in_inst[20], in_inst[30:21], 1'b0};

    logic [5:0]  w_dec_op;
    logic [31:0] w_dec_imm;

    // Combinational decode of the incoming word into op index and immediate
    always_comb begin
        w_dec_op  = C_OP_ILLEGAL;
        w_dec_imm = '0;
        // opcode[1:0] must be 2'b11 for every listed opcode, so a compressed
        // or malformed word falls through to the illegal default.
        case (w_opcode)
            7'b0110111: begin w_dec_op = 6'd0; w_dec_imm = w_imm_u; end
            7'b0010111: begin w_dec_op = 6'd1; w_dec_imm = w_imm_u; end
            7'b1101111: begin w_dec_op = 6'd2; w_dec_imm = w_imm_j; end
            7'b1100111: begin
                if (w_f3 == 3'b000) w_dec_op = 6'd3;
                w_dec_imm = w_imm_i;
            end
            7'b1100011: begin
                case (w_f3)
                    3'b000:  w_dec_op = 6'd4;
                    3'b001:  w_dec_op = 6'd5;
                    3'b100:  w_dec_op = 6'd6;
                    3'b101:  w_dec_op = 6'd7;
                    3'b110:  w_dec_op = 6'd8;
                    3'b111:  w_dec_op = 6'd9;
                    default: w_dec_op = C_OP_ILLEGAL;
                endcase
                w_dec_imm = w_imm_b;
            end
            7'b0000011: begin
                case (w_f3)
                    3'b000:  w_dec_op = 6'd10;
                    3'b001:  w_dec_op = 6'd11;
                    3'b010:  w_dec_op = 6'd12;
                    3'b100:  w_dec_op = 6'd13;
                    3'b101:  w_dec_op = 6'd14;
                    default: w_dec_op = C_OP_ILLEGAL;
                endcase
                w_dec_imm = w_imm_i;
            end
            7'b0100011: begin
                case (w_f3)
                    3'b000:  w_dec_op = 6'd15;
                    3'b001:  w_dec_op = 6'd16;
                    3'b010:  w_dec_op = 6'd17;
                    default: w_dec_op = C_OP_ILLEGAL;
                endcase
                w_dec_imm = w_imm_s;
            end
            7'b0010011: begin
                case (w_f3)
                    3'b000:  w_dec_op = 6'd18;
                    3'b010:  w_dec_op = 6'd19;
                    3'b011:  w_dec_op = 6'd20;
                    3'b100:  w_dec_op = 6'd21;
                    3'b110:  w_dec_op = 6'd22;
                    3'b111:  w_dec_op = 6'd23;
                    3'b001:  if (w_f7 == 7'b0000000) w_dec_op = 6'd24;
                    3'b101: begin
                        if (w_f7 == 7'b0000000)      w_dec_op = 6'd25;
                        else if (w_f7 == 7'b0100000) w_dec_op = 6'd26;
                    end
                    default: w_dec_op = C_OP_ILLEGAL;
                endcase
                // Shift-immediates keep the raw 12-bit field, funct7 included.
                w_dec_imm = w_imm_i;
            end
            7'b0110011: begin
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_dec_op = 6'd27;
                        3'b001:  w_dec_op = 6'd29;
                        3'b010:  w_dec_op = 6'd30;
                        3'b011:  w_dec_op = 6'd31;
                        3'b100:  w_dec_op = 6'd32;
                        3'b101:  w_dec_op = 6'd33;
                        3'b110:  w_dec_op = 6'd35;
                        default: w_dec_op = 6'd36;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    case (w_f3)
                        3'b000:  w_dec_op = 6'd28;
                        3'b101:  w_dec_op = 6'd34;
                        default: w_dec_op = C_OP_ILLEGAL;
                    endcase
                end
`ifdef DECODE_RV32M_EN
                else if (w_f7 == 7'b0000001) begin
                    w_dec_op = 6'd40 + {3'b000, w_f3};
                end
`endif
            end
            7'b0001111: begin
                if (w_f3 == 3'b000) w_dec_op = 6'd37;
                w_dec_imm = w_imm_i;
            end
            7'b1110011: begin
                // Only the two environment calls are supported; CSR forms
                // and other funct12 values are illegal.
                if (w_f3 == 3'b000 && in_inst[31:20] == 12'h000)      w_dec_op = 6'd38;
                else if (w_f3 == 3'b000 && in_inst[31:20] == 12'h001) w_dec_op = 6'd39;
                w_dec_imm = w_imm_i;
            end
            default: w_dec_op = C_OP_ILLEGAL;
        endcase
        if (w_dec_op == C_OP_ILLEGAL) w_dec_imm = '0;
    end

    entry_t w_entry_d;

    // Pack the decoded instruction into a buffer entry
    always_comb begin
        w_entry_d         = '0;
        w_entry_d.op      = w_dec_op;
        w_entry_d.rd      = in_inst[11:7];
        w_entry_d.rs1     = in_inst[19:15];
        w_entry_d.rs2     = in_inst[24:20];
        w_entry_d.imm     = w_dec_imm;
        w_entry_d.pc      = in_pc;
        w_entry_d.illegal = (w_dec_op == C_OP_ILLEGAL);
    end

    // ------------------------------------------------------------------
    // Circular buffer control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [3:0]       occupancy_q;
    logic [3:0]       occupancy_d;
    logic             w_accept;
    logic             w_retire;
    entry_t           mem_q [DEPTH];
    entry_t           w_head;

    // Next-state for pointers and occupancy; flush beats accept and retire
    always_comb begin
        w_accept    = in_valid && in_ready && !flush;
        w_retire    = out_valid && out_ready && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occupancy_d = occupancy_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occupancy_d = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_retire) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_accept, w_retire})
                2'b10:   occupancy_d = occupancy_q + 4'd1;
                2'b01:   occupancy_d = occupancy_q - 4'd1;
                default: occupancy_d = occupancy_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Entry storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (w_accept) mem_q[wr_ptr_q] <= w_entry_d;
    end

    assign w_head = mem_q[rd_ptr_q];

    // Handshake and head outputs; an empty buffer presents the idle values
    always_comb begin
        occupancy   = occupancy_q;
        out_valid   = (occupancy_q != 4'd0);
        in_ready    = (occupancy_q < C_DEPTH);
        out_op      = C_OP_ILLEGAL;
        out_rd      = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_imm     = '0;
        out_pc      = '0;
        out_illegal = 1'b0;
        if (occupancy_q != 4'd0) begin
            out_op      = w_head.op;
            out_rd      = w_head.rd;
            out_rs1     = w_head.rs1;
            out_rs2     = w_head.rs2;
            out_imm     = w_head.imm;
            out_pc      = w_head.pc;
            out_illegal = w_head.illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_decode_pipe
// Desc     : Self-checking bench for core_decode_pipe. A table-driven RV32
//            encoding model feeds a queue of expected entries that is compared
//            against the DUT on every falling edge; directed vectors carry
//            hand-computed literal expectations. Honours DECODE_RV32M_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_decode_pipe;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int F_I = 0, F_S = 1, F_B = 2, F_U = 3, F_J = 4, F_R = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [3:0]  occupancy;

    int tests_run    = 0;
    int tests_failed = 0;

    core_decode_pipe #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_illegal(out_illegal),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Encoding table: (mask, match) -> op index and immediate format
    // ------------------------------------------------------------------
    logic [31:0] t_mask [$];
    logic [31:0] t_match[$];
    int          t_op   [$];
    int          t_fmt  [$];

    task automatic add_enc(input logic [31:0] m, input logic [31:0] v, input int op, input int fmt);
        t_mask.push_back(m);
        t_match.push_back(v);
        t_op.push_back(op);
        t_fmt.push_back(fmt);
    endtask

    task automatic build_table();
        int bf[6];
        int lf[5];
        int af[6];
        int rf7[10];
        int rf3[10];
        bf  = '{0, 1, 4, 5, 6, 7};
        lf  = '{0, 1, 2, 4, 5};
        af  = '{0, 2, 3, 4, 6, 7};
        rf7 = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        rf3 = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        add_enc(32'h0000007F, 32'h00000037, 0, F_U);
        add_enc(32'h0000007F, 32'h00000017, 1, F_U);
        add_enc(32'h0000007F, 32'h0000006F, 2, F_J);
        add_enc(32'h0000707F, 32'h00000067, 3, F_I);
        for (int k = 0; k < 6; k++) add_enc(32'h0000707F, 32'h63 | 32'(bf[k] << 12), 4 + k, F_B);
        for (int k = 0; k < 5; k++) add_enc(32'h0000707F, 32'h03 | 32'(lf[k] << 12), 10 + k, F_I);
        for (int k = 0; k < 3; k++) add_enc(32'h0000707F, 32'h23 | 32'(k << 12), 15 + k, F_S);
        for (int k = 0; k < 6; k++) add_enc(32'h0000707F, 32'h13 | 32'(af[k] << 12), 18 + k, F_I);
        add_enc(32'hFE00707F, 32'h00001013, 24, F_I);
        add_enc(32'hFE00707F, 32'h00005013, 25, F_I);
        add_enc(32'hFE00707F, 32'h40005013, 26, F_I);
        for (int k = 0; k < 10; k++)
            add_enc(32'hFE00707F, 32'h33 | 32'(rf7[k] << 25) | 32'(rf3[k] << 12), 27 + k, F_R);
        add_enc(32'h0000707F, 32'h0000000F, 37, F_I);
        add_enc(32'hFFF0707F, 32'h00000073, 38, F_I);
        add_enc(32'hFFF0707F, 32'h00100073, 39, F_I);
`ifdef DECODE_RV32M_EN
        for (int k = 0; k < 8; k++) add_enc(32'hFE00707F, 32'h02000033 | 32'(k << 12), 40 + k, F_R);
`endif
    endtask

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    function automatic exp_t model_entry(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        int   fmt;
        int   si;
        e     = '0;
        e.op  = 6'd63;
        e.ill = 1'b1;
        fmt   = F_R;
        for (int k = 0; k < t_op.size(); k++) begin
            if ((i & t_mask[k]) == t_match[k]) begin
                e.op  = 6'(t_op[k]);
                e.ill = 1'b0;
                fmt   = t_fmt[k];
                break;
            end
        end
        si    = $signed(i);
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.pc  = p;
        case (fmt)
            F_I:     e.imm = 32'(si >>> 20);
            F_S:     e.imm = (32'(si >>> 25) << 5) | 32'(i[11:7]);
            F_B:     e.imm = (32'(si >>> 31) << 12) | (32'(i[7]) << 11)
                             | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            F_U:     e.imm = i & 32'hFFFFF000;
            F_J:     e.imm = (32'(si >>> 31) << 20) | (32'(i[19:12]) << 12)
                             | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Reference queue: follows transfers as the handshake rules define them
    // ------------------------------------------------------------------
    exp_t mq[$];
    bit   m_ret;
    bit   m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            m_ret = (mq.size() != 0) && out_ready;
            m_acc = in_valid && (mq.size() < DEPTH);
            if (m_ret) void'(mq.pop_front());
            if (m_acc) mq.push_back(model_entry(in_inst, in_pc));
        end
    end

    // Per-cycle comparison of DUT state against the reference queue
    always @(negedge clk) begin
        if (!rst) begin
            check("occupancy", 64'(occupancy), 64'(mq.size()));
            check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("head_op", 64'(out_op), 64'(mq[0].op));
                check("head_rd", 64'(out_rd), 64'(mq[0].rd));
                check("head_rs1", 64'(out_rs1), 64'(mq[0].rs1));
                check("head_rs2", 64'(out_rs2), 64'(mq[0].rs2));
                check("head_imm", 64'(out_imm), 64'(mq[0].imm));
                check("head_pc", 64'(out_pc), 64'(mq[0].pc));
                check("head_illegal", 64'(out_illegal), 64'(mq[0].ill));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at the next one)
    // ------------------------------------------------------------------
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic fl, input logic ordy);
        in_valid  = v;
        in_inst   = ins;
        in_pc     = p;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic send_one(input logic [31:0] ins, input logic [31:0] p);
        cyc(1'b1, ins, p, 1'b0, 1'b0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 12 && mq.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_op"}, 64'(out_op), 64'd63);
        check({tag, "_imm"}, 64'(out_imm), 64'd0);
        check({tag, "_regs"}, 64'({out_rd, out_rs1, out_rs2}), 64'd0);
        check({tag, "_pc"}, 64'(out_pc), 64'd0);
        check({tag, "_illegal"}, 64'(out_illegal), 64'd0);
    endtask

    logic [31:0] sweep[20];

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        build_table();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ADDI with negative immediate, presented one cycle after accept
        send_one(32'hC0138A93, 32'h100);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_op", 64'(out_op), 64'd18);
        check("addi_imm", 64'(out_imm), 64'hFFFFFC01);
        check("addi_rs1", 64'(out_rs1), 64'd7);
        check("addi_rd", 64'(out_rd), 64'd21);
        check("addi_pc", 64'(out_pc), 64'h100);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("addi_hold_op", 64'(out_op), 64'd18);
        check("addi_hold_imm", 64'(out_imm), 64'hFFFFFC01);
        drain();

        // SRA: register form, zero immediate (listing order puts SRA at 34)
        send_one(32'h4013DAB3, 32'h104);
        check("sra_op", 64'(out_op), 64'd34);
        check("sra_rs2", 64'(out_rs2), 64'd1);
        check("sra_rs1", 64'(out_rs1), 64'd7);
        check("sra_rd", 64'(out_rd), 64'd21);
        check("sra_imm", 64'(out_imm), 64'd0);

        // JAL accepted in the same cycle the SRA retires
        cyc(1'b1, 32'h7FE991EF, 32'h108, 1'b0, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("jal_occupancy", 64'(occupancy), 64'd1);
        check("jal_op", 64'(out_op), 64'd2);
        check("jal_rd", 64'(out_rd), 64'd3);
        check("jal_imm", 64'(out_imm), 64'h000997FE);
        check("jal_pc", 64'(out_pc), 64'h108);
        drain();

        // MUL: legal only with the multiply/divide extension
        send_one(32'h02A383B3, 32'h10C);
`ifdef DECODE_RV32M_EN
        check("mul_op", 64'(out_op), 64'd40);
        check("mul_illegal", 64'(out_illegal), 64'd0);
`else
        check("mul_op", 64'(out_op), 64'd63);
        check("mul_illegal", 64'(out_illegal), 64'd1);
`endif
        check("mul_imm", 64'(out_imm), 64'd0);
        check("mul_rd", 64'(out_rd), 64'd7);
        drain();

        // BEQ x1,x2,-8 and SW x5,-4(x2)
        send_one(32'hFE208CE3, 32'h110);
        check("beq_op", 64'(out_op), 64'd4);
        check("beq_imm", 64'(out_imm), 64'hFFFFFFF8);
        check("beq_rd_raw", 64'(out_rd), 64'd25);
        drain();
        send_one(32'hFE512E23, 32'h114);
        check("sw_op", 64'(out_op), 64'd17);
        check("sw_imm", 64'(out_imm), 64'hFFFFFFFC);
        check("sw_rs2", 64'(out_rs2), 64'd5);
        drain();
        send_one(32'h12345537, 32'h118);
        check("lui_op", 64'(out_op), 64'd0);
        check("lui_imm", 64'(out_imm), 64'h12345000);
        check("lui_rd", 64'(out_rd), 64'd10);
        drain();

        // Backpressure: third input stalls while full, then order is kept
        cyc(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h40208233, 32'h204, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_occupancy", 64'(occupancy), 64'd2);
        cyc(1'b1, 32'h0020C2B3, 32'h208, 1'b0, 1'b0);
        check("stall_occupancy", 64'(occupancy), 64'd2);
        check("stall_head_pc", 64'(out_pc), 64'h200);
        cyc(1'b1, 32'h0020C2B3, 32'h208, 1'b0, 1'b1);
        check("release1_pc", 64'(out_pc), 64'h204);
        cyc(1'b1, 32'h0020C2B3, 32'h208, 1'b0, 1'b1);
        check("release2_pc", 64'(out_pc), 64'h208);
        check("release2_occupancy", 64'(occupancy), 64'd1);
        drain();

        // Flush while full with a same-cycle input
        cyc(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h00A00113, 32'h304, 1'b0, 1'b0);
        cyc(1'b1, 32'h00F00193, 32'h308, 1'b1, 1'b1);
        check("flush_occupancy", 64'(occupancy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("flush_dropped", 64'(out_valid), 64'd0);
        // Flush at occupancy 1: the input is dropped even though ready
        cyc(1'b1, 32'h00100213, 32'h30C, 1'b0, 1'b0);
        cyc(1'b1, 32'h00200293, 32'h310, 1'b1, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush1_occupancy", 64'(occupancy), 64'd0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush1_dropped", 64'(out_valid), 64'd0);

        // Decode sweep, checked against the model every cycle
        sweep = '{32'h12345537, 32'h00001097, 32'h000080E7, 32'h000090E7,
                  32'h0040A103, 32'h0030F093, 32'h00209093, 32'h4020D093,
                  32'h0220D093, 32'h0000000F, 32'h00000073, 32'h00100073,
                  32'h00200073, 32'hFFFFFFFF, 32'h00000013, 32'h00A08032,
                  32'h0020A063, 32'h0420F0B3, 32'h02A3C3B3, 32'h8000006F};
        for (int k = 0; k < 20; k++)
            cyc(1'b1, sweep[k], 32'h400 + 32'(4 * k), 1'b0, (k % 3) != 0);
        drain();

        // Reset mid-operation while full
        cyc(1'b1, 32'h00500093, 32'h500, 1'b0, 1'b0);
        cyc(1'b1, 32'h00A00113, 32'h504, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("prerst_occupancy", 64'(occupancy), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("postrst_no_entry", 64'(out_valid), 64'd0);
        send_one(32'hC0138A93, 32'h600);
        check("postrst_valid", 64'(out_valid), 64'd1);
        check("postrst_pc", 64'(out_pc), 64'h600);
        check("postrst_occupancy", 64'(occupancy), 64'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
